// File: rtl/dpa_pkg.sv
// dpa_pkg: shared types for the wide dual-path-adder sequencer.
//   DPA_N_DEFAULT : default width of the external N-bit adder
//   dpa_state_e   : sequencer FSM states
//   dpa_flags_t   : registered result status flags
package dpa_pkg;

    localparam int DPA_N_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } dpa_state_e;

    typedef struct packed {
        logic cout;
        logic negative;
        logic overflow;
        logic zero;
    } dpa_flags_t;

endpackage

// File: rtl/dpa_wide_sequencer.sv
// dpa_wide_sequencer: runs a 2N-bit add/subtract through an external N-bit
// adder in two passes (low half, then high half, carry chained between them).
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request; latch operands on accept
// LO    | adder fed low halves + c0; capture low sum and carry
// HI    | adder fed high halves + carry; capture high sum and flags
// DONE  | out_valid=1, result held until out_ready
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_a, in_b                2N-bit operands
//   in_sub, in_cin, in_signed operation select, add carry-in, signed flags
//   add_a/add_b/add_cin       drive to external adder
//   add_signed_en             tied 0, adder used in raw sum mode
//   add_sum/add_cout          result from external adder
//   out_valid/out_ready       result handshake
//   out_sum                   2N-bit result
//   out_cout/out_negative/out_overflow/out_zero  status flags
module dpa_wide_sequencer
    import dpa_pkg::*;
#(
    parameter int N = DPA_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_a,
    input  logic [2*N-1:0]   in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic             in_signed,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_cin,
    output logic             add_signed_en,
    input  logic [N-1:0]     add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_sum,
    output logic             out_cout,
    output logic             out_negative,
    output logic             out_overflow,
    output logic             out_zero
);

    dpa_state_e     state_q, state_d;
    logic [2*N-1:0] a_q;
    logic [2*N-1:0] b_q;        // already inverted for subtract
    logic           c0_q;
    logic           signed_q;
    logic           sub_q;
    logic           carry_q;
    logic [2*N-1:0] sum_q;
    dpa_flags_t     flags_q, flags_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Adder drive: low halves only in LO; every other state presents the
    // latched high halves so the adder inputs stay quiet outside a pass.
    always_comb begin
        if (state_q == LO) begin
            add_a   = a_q[N-1:0];
            add_b   = b_q[N-1:0];
            add_cin = c0_q;
        end else begin
            add_a   = a_q[2*N-1:N];
            add_b   = b_q[2*N-1:N];
            add_cin = carry_q;
        end
    end

    assign add_signed_en = 1'b0;

    // Flags from the high pass; the low half of the sum is already registered.
    always_comb begin
        flags_d.cout     = add_cout;
        flags_d.negative = signed_q & add_sum[N-1];
        if (signed_q)
            flags_d.overflow = (a_q[2*N-1] == b_q[2*N-1]) && (add_sum[N-1] != a_q[2*N-1]);
        else if (sub_q)
            flags_d.overflow = ~add_cout;
        else
            flags_d.overflow = add_cout;
        flags_d.zero     = (add_sum == '0) && (sum_q[N-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            c0_q     <= 1'b0;
            signed_q <= 1'b0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_sub ? ~in_b : in_b;
                        c0_q     <= in_sub ? 1'b1 : in_cin;
                        signed_q <= in_signed;
                        sub_q    <= in_sub;
                    end
                end
                LO: begin
                    sum_q[N-1:0] <= add_sum;
                    carry_q      <= add_cout;
                end
                HI: begin
                    sum_q[2*N-1:N] <= add_sum;
                    flags_q        <= flags_d;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_sum      = sum_q;
    assign out_cout     = flags_q.cout;
    assign out_negative = flags_q.negative;
    assign out_overflow = flags_q.overflow;
    assign out_zero     = flags_q.zero;

endmodule

// File: tb/tb_dpa_wide_sequencer.sv
module tb_dpa_wide_sequencer;

    localparam int N = 64;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         in_signed;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic         add_signed_en;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_negative;
    logic         out_overflow;
    logic         out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Raw-sum N-bit adder standing in for the DPA1 instance.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    dpa_wide_sequencer #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_sub        (in_sub),
        .in_cin        (in_cin),
        .in_signed     (in_signed),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_cin       (add_cin),
        .add_signed_en (add_signed_en),
        .add_sum       (add_sum),
        .add_cout      (add_cout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_cout      (out_cout),
        .out_negative  (out_negative),
        .out_overflow  (out_overflow),
        .out_zero      (out_zero)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns cycles counted from the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] e_sum,
                              input logic e_cout, input logic e_neg,
                              input logic e_ovf, input logic e_zero);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".sum"},   out_sum,   e_sum);
        chk({tag, ".cout"},  out_cout,  e_cout);
        chk({tag, ".neg"},   out_negative, e_neg);
        chk({tag, ".ovf"},   out_overflow, e_ovf);
        chk({tag, ".zero"},  out_zero,  e_zero);
    endtask

    // One full transaction; called with the DUT idle and inputs presented #1 after an edge.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, input logic sgn,
                         input logic [W-1:0] e_sum, input logic e_cout, input logic e_neg,
                         input logic e_ovf, input logic e_zero);
        int lat;
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_signed = sgn;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk({tag, ".busy"}, in_ready, 1'b0);
        wait_valid(lat);
        chk({tag, ".lat"}, lat, 3);
        chk_result(tag, e_sum, e_cout, e_neg, e_ovf, e_zero);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".released"}, out_valid, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; in_signed = 1'b0;
        step(); step();
        rst = 1'b0;

        chk("rst.in_ready",  in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_sum",   out_sum, '0);
        chk("rst.flags",     {out_cout, out_negative, out_overflow, out_zero}, 4'b0);
        chk("rst.signed_en", add_signed_en, 1'b0);

        do_op("add_carry", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b0,
              128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("usub_neg", 128'd0, 128'd1, 1'b1, 1'b0, 1'b0,
              {W{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("ssub_neg", 128'd0, 128'd1, 1'b1, 1'b0, 1'b1,
              {W{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("sadd_ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b1,
              128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op("uzero", 128'd5, 128'd5, 1'b1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("szero", 128'd5, 128'd5, 1'b1, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("add_cin", 128'd1, 128'd2, 1'b0, 1'b1, 1'b0, 128'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub_cin_ign", 128'd10, 128'd3, 1'b1, 1'b1, 1'b0, 128'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("uadd_ovf", {W{1'b1}}, 128'd2, 1'b0, 1'b0, 1'b0, 128'd1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held while a new request waits.
        in_a = 128'd3; in_b = 128'd4; in_sub = 1'b0; in_cin = 1'b0; in_signed = 1'b0;
        in_valid = 1'b1;
        step();
        in_a = 128'd100; in_b = 128'd200;
        wait_valid(lat);
        chk("bp.lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk_result("bp.hold", 128'd7, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp.in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.idle_valid", out_valid, 1'b0);
        chk("bp.idle_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp.accepted", in_ready, 1'b0);
        wait_valid(lat);
        chk("bp2.lat", lat, 3);
        chk_result("bp2", 128'd300, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while in HI.
        in_a = 128'd9; in_b = 128'd9; in_sub = 1'b0; in_cin = 1'b0; in_signed = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid.in_hi", in_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid.in_ready",  in_ready, 1'b1);
        chk("mid.out_valid", out_valid, 1'b0);
        chk("mid.out_sum",   out_sum, '0);
        step();
        chk("mid.no_result", out_valid, 1'b0);
        do_op("after_rst", 128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'd1, 1'b1, 1'b0, 1'b0,
              128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpa_wide_sequencer.md
Name: dpa_wide_sequencer

Overview:
- Upstream/downstream control stage wrapped around the N-bit combinational dual-path adder.
- Accepts a 2N-bit add/subtract request over a valid/ready handshake.
- Drives the adder twice: low half first, then high half, chaining carry between passes.
- Returns a registered 2N-bit result with status flags over a valid/ready handshake.

Parameters:
- N, 64, width of the external adder; operands and result are 2N bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  sequencer can accept a request
- in_a  input  2N  operand A
- in_b  input  2N  operand B
- in_sub  input  1  0 = A+B+in_cin, 1 = A-B (in_cin ignored)
- in_cin  input  1  carry-in for add
- in_signed  input  1  signed interpretation for flags
- add_a  output  N  adder operand a
- add_b  output  N  adder operand b
- add_cin  output  1  adder carry-in
- add_signed_en  output  1  tied 0 (raw sum mode)
- add_sum  input  N  adder final_sum
- add_cout  input  1  adder cout
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  2N  result
- out_cout  output  1  carry out of bit 2N-1
- out_negative  output  1  negative flag
- out_overflow  output  1  overflow/borrow flag
- out_zero  output  1  out_sum == 0

Behaviour:
- FSM states: IDLE, LO, HI, DONE.
- Reset: state=IDLE; in_ready=1; out_valid=0; out_sum=0; all flags 0; internal operand and carry registers 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch A, B' and c0, plus in_signed and in_sub, then go to LO.
  - B' = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- LO:
  - add_a=A[N-1:0], add_b=B'[N-1:0], add_cin=c0.
  - Capture add_sum into sum[N-1:0] and add_cout into carry register, then go to HI.
- HI:
  - add_a=A[2N-1:N], add_b=B'[2N-1:N], add_cin=carry register.
  - Capture add_sum into sum[2N-1:N], compute flags, then go to DONE.
- Adder inputs are don't-care in IDLE and DONE; drive them from the latched registers so they do not toggle.
- Flags, computed in HI and registered with sum:
  - out_cout = add_cout of the high pass.
  - out_negative = in_signed & sum[2N-1].
  - out_overflow, signed: A[2N-1]==B'[2N-1] && sum[2N-1]!=A[2N-1].
  - out_overflow, unsigned add: cout.
  - out_overflow, unsigned sub: ~cout (borrow).
  - out_zero = (sum==0).
- DONE:
  - out_valid=1; outputs held stable until out_valid&out_ready, then go to IDLE.
  - No output combinational path from out_ready.
- Latency: accept edge = cycle 0; out_valid high in cycle 3. Throughput: 1 request per 4 cycles with out_ready held high.
- in_ready=0 in LO, HI and DONE; in_valid is ignored there and the operands are not sampled.
- Reset mid-operation (any state): next cycle IDLE, out_valid=0, in-flight request discarded.
- Flags stay registered after leaving DONE, but are meaningful only while out_valid=1.

Decomposition:
- Package dpa_pkg:
  - Default N.
  - FSM state enum {IDLE, LO, HI, DONE}.
  - Flag struct {cout, negative, overflow, zero}.
- Single module, no sub-module. The adder is instantiated alongside by the parent, not inside this block.
- Bench connects a DPA1 instance to the add_* ports.

Test Plan (N=64, 128-bit values):
- Unsigned add with carry across halves:
  - A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, in_sub=0, in_cin=0.
  - out_sum=0x0000_0000_0000_0001_0000_0000_0000_0000.
  - cout=0, overflow=0, zero=0; out_valid exactly 3 cycles after accept.
- Unsigned and signed subtract below zero, A=0, B=1, in_sub=1:
  - Unsigned: out_sum=all ones, cout=0, overflow=1 (borrow), negative=0.
  - Signed: same sum, negative=1, overflow=0.
- Signed add overflow:
  - A=0x7FFF…FFFF, B=1, in_signed=1.
  - out_sum=0x8000…0000, overflow=1, negative=1, cout=0.
- Zero result:
  - A=5, B=5, in_sub=1.
  - out_sum=0, zero=1, cout=1, overflow=0 (unsigned and signed).
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - out_sum and flags stay stable; in_ready=0; new request not taken.
  - Raise out_ready: IDLE next cycle, new request accepted that cycle, its result correct.
- Reset mid-operation:
  - Assert rst for 1 cycle while in HI.
  - Next cycle: IDLE, in_ready=1, out_valid=0.
  - Following request completes normally with correct result.
